// File: rtl/uart_rx.sv
// UART receiver: synchronised rx line, strobe-driven mid-bit sampling, LSB-first
// deserialiser and a one-entry valid/ready holding register. Define UART_RX_PARITY_EN for even parity.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_rx_strb,
    output logic       o_rx_strb_en,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   strb_en_q, strb_en_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;
    logic                   load;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
    logic parity_bad;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign parity_bad = ^{shift_q, par_q};
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_rx};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        load        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if (valid_q && i_rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (i_rx_strb) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (i_rx_strb) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (i_rx_strb) begin
                    par_d   = rx_s;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (i_rx_strb) begin
`ifdef UART_RX_PARITY_EN
                    parity_err_d = parity_bad;
`endif
                    if (rx_s) begin
                        load    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line stays here so a break never looks like a new start bit.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (!valid_q || i_rx_ready) begin
                data_d  = 8'(shift_q);
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        strb_en_d = (state_d == S_START) || (state_d == S_DATA) ||
`ifdef UART_RX_PARITY_EN
                    (state_d == S_PARITY) ||
`endif
                    (state_d == S_STOP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            strb_en_q   <= 1'b0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            strb_en_q   <= strb_en_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_rx_strb_en = strb_en_q;
    assign o_rx_data    = data_q;
    assign o_rx_valid   = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the RX strobe from the UART baud generator and drives that generator's RX enable.
- Detects the start bit, samples each bit once per strobe (mid-bit), deserialises LSB first, and checks the stop bit.
- Presents each received byte on a valid/ready holding register to the AXI4-Lite register block.
- Sits between the pad-level rx line and the UART RX data/status registers.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser; minimum 2.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
i_rx  input  1  asynchronous serial line, idle high
i_rx_strb  input  1  one-cycle mid-bit sample strobe from the baud generator
o_rx_strb_en  output  1  enables the baud generator RX counter; low restarts its phase
o_rx_data  output  8  received byte; bits above DATA_BITS are zero
o_rx_valid  output  1  o_rx_data holds an unread byte
i_rx_ready  input  1  consumer accepts the byte when o_rx_valid && i_rx_ready
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full
o_parity_err  output  1  one-cycle pulse: parity mismatch (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n.
- Reset values:
  - Synchroniser stages all 1; state IDLE.
  - o_rx_strb_en=0, o_rx_data=0, o_rx_valid=0.
  - o_frame_err, o_overrun, o_parity_err all 0.
- rx_s is i_rx after the SYNC_STAGES-flop synchroniser. All decisions use rx_s.
- o_rx_strb_en is registered: 1 exactly when the state is START, DATA, PARITY or STOP.
- The baud generator fires its first strobe about half a bit period after enable, then one strobe per bit.
- States and transitions:
  - IDLE: rx_s==0 -> START. i_rx_strb is ignored.
  - START: on strobe, rx_s==1 -> IDLE (false start; no outputs change). rx_s==0 -> DATA with bit_cnt=0.
  - DATA: on each strobe, shift rx_s in (LSB first) and increment bit_cnt. After the DATA_BITS-th strobe -> PARITY if the feature is compiled in, else STOP.
  - PARITY: on strobe, capture the parity bit -> STOP.
  - STOP, on strobe, rx_s==1: load the byte per the holding rules below -> IDLE.
  - STOP, on strobe, rx_s==0: pulse o_frame_err and discard the byte -> BREAK.
  - BREAK: o_rx_strb_en=0. Wait for rx_s==1 -> IDLE. A held-low line (break) never re-triggers START.
- Latency: o_rx_valid rises on the cycle after the STOP strobe cycle.
- Holding register, evaluated on the load cycle (the STOP strobe with rx_s==1):
  - o_rx_valid==0: load the byte and set valid.
  - o_rx_valid==1 && i_rx_ready==1: the old byte is consumed; load the new byte; valid stays 1; no overrun.
  - o_rx_valid==1 && i_rx_ready==0: keep the old byte; drop the new one; pulse o_overrun.
- Outside a load cycle, o_rx_valid && i_rx_ready clears o_rx_valid next cycle. o_rx_data is unchanged until the next load.
- Error pulses last exactly one cycle and are registered alongside the load or discard decision.
- Synchronous reset mid-frame returns to IDLE next edge, drops o_rx_strb_en and clears the holding register.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit follows the data bits, and the PARITY state exists.
  - On a mismatch, o_parity_err pulses on the load cycle and the byte is still delivered.
  - If the frame also fails its stop bit, both o_parity_err and o_frame_err pulse and the byte is discarded.
- Undefined: no parity bit or PARITY state; o_parity_err is tied to 0.

Test Plan:
- Setup for all scenarios: CLK_FREQ=100 MHz, baud generator at 115200 (divider 868), instantiated alongside, DATA_BITS=8.
- Frame 0xA5 with good stop, i_rx_ready=1 after 3 cycles -> o_rx_data=0xA5, o_rx_valid high until the handshake, no error pulses, o_rx_strb_en=0 after STOP.
- rx low for 200 cycles then high -> no byte, no errors, o_rx_strb_en returns to 0, next valid frame 0x3C received correctly.
- Frame 0x3C with stop bit 0, then line held low for 5 bit times -> one o_frame_err pulse, o_rx_valid stays 0, no new START until the line goes high. Next frame 0x55 is received correctly.
- Bytes 0x11 then 0x22 with i_rx_ready=0 -> o_rx_data=0x11, one o_overrun pulse at the second STOP. Raising ready then yields 0x11 once and valid clears.
- Bytes 0x11 then 0x22 with i_rx_ready=1 only on the second load cycle -> no overrun, o_rx_data=0x22, valid continuously high.
- UART_RX_PARITY_EN defined: 0x01 with parity bit 0 -> o_parity_err pulse, o_rx_data=0x01 valid. 0x01 with parity bit 1 -> no error.
